// File: rtl/life_input_editor.sv
// Control stage for the Game of Life array: cursor-driven edit buffer,
// EDIT/LOAD/RUN/CAPTURE sequencing and generation pacing via freeze pulses.
module life_input_editor #(
    parameter int GRID         = 16,
    parameter int TICK_PERIOD  = 50_000_000,
    parameter int BLINK_PERIOD = 12_500_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_up,
    input  logic                           key_down,
    input  logic                           key_left,
    input  logic                           key_right,
    input  logic                           key_toggle,
    input  logic                           key_clear,
    input  logic                           run_sw,
    input  logic [GRID-1:0][GRID-1:0]      cell_status,
    output logic [GRID-1:0][GRID-1:0]      user_input,
    output logic                           game_state,
    output logic                           freeze,
    output logic [$clog2(GRID)-1:0]        cursor_row,
    output logic [$clog2(GRID)-1:0]        cursor_col,
    output logic                           cursor_blink
);
    localparam int RW = $clog2(GRID);
    localparam int TW = $clog2(TICK_PERIOD);
    localparam int BW = $clog2(BLINK_PERIOD);
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

    localparam logic [1:0] S_EDIT    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [5:0]               key_prev_q, key_prev_d, keys, key_ev;
    logic [RW-1:0]            row_q, row_d, col_q, col_d;
    logic [GRID-1:0][GRID-1:0] buf_q, buf_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [BW-1:0]            bcnt_q, bcnt_d;
    logic                     blink_q, blink_d;
    logic                     game_state_q, game_state_d;
    logic                     freeze_q, freeze_d;
    logic                     moved;

    always_comb begin
        // key bit order: toggle, clear, up, down, left, right
        keys       = {key_toggle, key_clear, key_up, key_down, key_left, key_right};
        key_ev     = keys & ~key_prev_q;
        key_prev_d = keys;
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        buf_d      = buf_q;
        tick_d     = tick_q;
        case (state_q)
            S_EDIT: begin
                if (key_ev[3] && !key_ev[2]) row_d = row_q - ROW_ONE;
                if (key_ev[2] && !key_ev[3]) row_d = row_q + ROW_ONE;
                if (key_ev[1] && !key_ev[0]) col_d = col_q - ROW_ONE;
                if (key_ev[0] && !key_ev[1]) col_d = col_q + ROW_ONE;
                // toggle uses the pre-move cursor; clear overrides it
                if (key_ev[4])      buf_d = '0;
                else if (key_ev[5]) buf_d[row_q][col_q] = ~buf_q[row_q][col_q];
                if (run_sw) state_d = S_LOAD;
            end
            S_LOAD: begin
                tick_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
                if (!run_sw) state_d = S_CAPTURE;
            end
            default: begin
                buf_d   = cell_status;
                state_d = S_EDIT;
            end
        endcase

        moved        = (row_d != row_q) || (col_d != col_q);
        game_state_d = (state_d == S_RUN) || (state_d == S_CAPTURE);
        freeze_d     = !((state_d == S_LOAD) ||
                         (state_q == S_RUN && state_d == S_RUN && tick_q == TICK_LAST));

        if (moved) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            blink_d = blink_q;
            bcnt_d  = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_EDIT;
            key_prev_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            buf_q        <= '0;
            tick_q       <= '0;
            bcnt_q       <= '0;
            blink_q      <= 1'b0;
            game_state_q <= 1'b0;
            freeze_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            key_prev_q   <= key_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
            buf_q        <= buf_d;
            tick_q       <= tick_d;
            bcnt_q       <= bcnt_d;
            blink_q      <= blink_d;
            game_state_q <= game_state_d;
            freeze_q     <= freeze_d;
        end
    end

    assign user_input   = buf_q;
    assign game_state   = game_state_q;
    assign freeze       = freeze_q;
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;
    assign cursor_blink = blink_q;
endmodule

// File: tb/tb_life_input_editor.sv
// Bench for life_input_editor: directed vector table, hand sequences for the
// phase transitions, and random stimulus against a cycle-level reference model.
module tb_life_input_editor;
    localparam int G  = 16;
    localparam int TP = 4;
    localparam int BP = 3;

    localparam logic [5:0] K_TOG = 6'b100000;
    localparam logic [5:0] K_CLR = 6'b010000;
    localparam logic [5:0] K_UP  = 6'b001000;
    localparam logic [5:0] K_DN  = 6'b000100;
    localparam logic [5:0] K_LF  = 6'b000010;
    localparam logic [5:0] K_RT  = 6'b000001;

    logic clk = 1'b0;
    logic reset, key_up, key_down, key_left, key_right, key_toggle, key_clear, run_sw;
    logic [G-1:0][G-1:0] cell_status, user_input;
    logic game_state, freeze, cursor_blink;
    logic [3:0] cursor_row, cursor_col;

    int checks = 0;
    int errors = 0;

    life_input_editor #(.GRID(G), .TICK_PERIOD(TP), .BLINK_PERIOD(BP)) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .key_toggle(key_toggle), .key_clear(key_clear), .run_sw(run_sw),
        .cell_status(cell_status), .user_input(user_input),
        .game_state(game_state), .freeze(freeze),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_blink(cursor_blink)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 edit, 1 load, 2 run, 3 capture
    int m_mode, m_row, m_col, m_run_age, m_blink_age;
    bit m_blink_base, m_gs, m_fr;
    logic [5:0] m_prev;
    logic [G-1:0][G-1:0] m_buf;

    function automatic void m_step();
        logic [5:0] k, ev;
        int nxt, dr, dc;
        bit mv;
        if (reset) begin
            m_mode = 0; m_row = 0; m_col = 0; m_buf = '0; m_prev = '0;
            m_run_age = 0; m_blink_age = 0; m_blink_base = 0; m_gs = 0; m_fr = 1;
            return;
        end
        k = {key_toggle, key_clear, key_up, key_down, key_left, key_right};
        ev = k & ~m_prev;
        m_prev = k;
        mv = 0;
        nxt = m_mode;
        case (m_mode)
            0: begin
                dr = int'(ev[2]) - int'(ev[3]);
                dc = int'(ev[0]) - int'(ev[1]);
                if (ev[4]) m_buf = '0;
                else if (ev[5]) m_buf[m_row][m_col] = ~m_buf[m_row][m_col];
                mv = (dr != 0) || (dc != 0);
                m_row = (m_row + dr + G) % G;
                m_col = (m_col + dc + G) % G;
                nxt = run_sw ? 1 : 0;
            end
            1: begin nxt = 2; m_run_age = 0; end
            2: begin m_run_age++; nxt = run_sw ? 2 : 3; end
            default: begin m_buf = cell_status; nxt = 0; end
        endcase
        m_mode = nxt;
        m_gs = (nxt >= 2);
        m_fr = !(nxt == 1 || (nxt == 2 && m_run_age > 0 && m_run_age % TP == 0));
        if (mv) begin m_blink_base = 1; m_blink_age = 0; end
        else m_blink_age++;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        bit exp_blink;
        m_step();
        @(posedge clk);
        #1;
        exp_blink = m_blink_base ^ bit'((m_blink_age / BP) % 2);
        chk("model_user_input", user_input, m_buf);
        chk("model_game_state", 256'(game_state), 256'(m_gs));
        chk("model_freeze", 256'(freeze), 256'(m_fr));
        chk("model_row", 256'(cursor_row), 256'(m_row));
        chk("model_col", 256'(cursor_col), 256'(m_col));
        chk("model_blink", 256'(cursor_blink), 256'(exp_blink));
    endtask

    task automatic set_keys(input logic [5:0] k);
        {key_toggle, key_clear, key_up, key_down, key_left, key_right} = k;
    endtask

    typedef struct {
        logic [5:0]  k;
        int          row;
        int          col;
        logic [15:0] r0;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] k, input int row, input int col, input logic [15:0] r0);
        vec_t v;
        v.k = k; v.row = row; v.col = col; v.r0 = r0;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [G-1:0][G-1:0] saved;
        logic [G-1:0][G-1:0] pat;
        logic [3:0] sr, sc;

        tbl.push_back(mk(K_LF, 0, 15, 16'h0)); tbl.push_back(mk(0, 0, 15, 16'h0));
        tbl.push_back(mk(K_LF, 0, 14, 16'h0)); tbl.push_back(mk(0, 0, 14, 16'h0));
        tbl.push_back(mk(K_LF, 0, 13, 16'h0)); tbl.push_back(mk(0, 0, 13, 16'h0));
        tbl.push_back(mk(K_RT, 0, 14, 16'h0)); tbl.push_back(mk(0, 0, 14, 16'h0));
        tbl.push_back(mk(K_RT, 0, 15, 16'h0)); tbl.push_back(mk(0, 0, 15, 16'h0));
        tbl.push_back(mk(K_RT, 0, 0, 16'h0));  tbl.push_back(mk(0, 0, 0, 16'h0));
        tbl.push_back(mk(K_TOG, 0, 0, 16'h1)); tbl.push_back(mk(0, 0, 0, 16'h1));
        tbl.push_back(mk(K_RT, 0, 1, 16'h1));  tbl.push_back(mk(0, 0, 1, 16'h1));
        tbl.push_back(mk(K_TOG, 0, 1, 16'h3)); tbl.push_back(mk(0, 0, 1, 16'h3));
        tbl.push_back(mk(K_LF, 0, 0, 16'h3));  tbl.push_back(mk(0, 0, 0, 16'h3));
        tbl.push_back(mk(K_TOG | K_RT, 0, 1, 16'h2)); tbl.push_back(mk(0, 0, 1, 16'h2));
        tbl.push_back(mk(K_TOG | K_CLR, 0, 1, 16'h0)); tbl.push_back(mk(0, 0, 1, 16'h0));
        tbl.push_back(mk(K_UP, 15, 1, 16'h0)); tbl.push_back(mk(0, 15, 1, 16'h0));
        tbl.push_back(mk(K_TOG, 15, 1, 16'h0)); tbl.push_back(mk(0, 15, 1, 16'h0));
        tbl.push_back(mk(K_UP | K_DN, 15, 1, 16'h0)); tbl.push_back(mk(0, 15, 1, 16'h0));
        tbl.push_back(mk(K_LF | K_RT, 15, 1, 16'h0)); tbl.push_back(mk(0, 15, 1, 16'h0));
        tbl.push_back(mk(K_DN, 0, 1, 16'h0));  tbl.push_back(mk(0, 0, 1, 16'h0));
        tbl.push_back(mk(K_DN, 1, 1, 16'h0));  tbl.push_back(mk(K_DN, 1, 1, 16'h0));
        tbl.push_back(mk(0, 1, 1, 16'h0));

        reset = 1'b1; set_keys('0); run_sw = 1'b0; cell_status = '0;
        tick(); tick();
        chk("rst_user_input", user_input, '0);
        chk("rst_game_state", 256'(game_state), 256'(0));
        chk("rst_freeze", 256'(freeze), 256'(1));
        chk("rst_row", 256'(cursor_row), 256'(0));
        chk("rst_col", 256'(cursor_col), 256'(0));
        chk("rst_blink", 256'(cursor_blink), 256'(0));
        reset = 1'b0;

        foreach (tbl[i]) begin
            set_keys(tbl[i].k);
            tick();
            chk($sformatf("vec%0d_row", i), 256'(cursor_row), 256'(tbl[i].row));
            chk($sformatf("vec%0d_col", i), 256'(cursor_col), 256'(tbl[i].col));
            chk($sformatf("vec%0d_row0", i), 256'(user_input[0]), 256'(tbl[i].r0));
        end
        chk("toggle_row15", 256'(user_input[15]), 256'(16'h0002));

        // EDIT -> LOAD -> RUN; keys are pressed during RUN and must be ignored
        saved = user_input; sr = cursor_row; sc = cursor_col;
        run_sw = 1'b1;
        tick();
        chk("load_game_state", 256'(game_state), 256'(0));
        chk("load_freeze", 256'(freeze), 256'(0));
        tick();
        chk("run0_game_state", 256'(game_state), 256'(1));
        chk("run0_freeze", 256'(freeze), 256'(1));
        for (int k = 1; k <= 12; k++) begin
            set_keys(6'($urandom));
            tick();
            chk($sformatf("run%0d_freeze", k), 256'(freeze), 256'((k % TP == 0) ? 0 : 1));
            chk($sformatf("run%0d_game_state", k), 256'(game_state), 256'(1));
        end
        chk("run_buf_kept", user_input, saved);
        chk("run_row_kept", 256'(cursor_row), 256'(sr));
        chk("run_col_kept", 256'(cursor_col), 256'(sc));

        // RUN -> CAPTURE -> EDIT with a known board
        set_keys('0);
        for (int r = 0; r < G; r++) pat[r] = 16'hA5A5;
        cell_status = pat;
        run_sw = 1'b0;
        tick();
        chk("cap_game_state", 256'(game_state), 256'(1));
        chk("cap_freeze", 256'(freeze), 256'(1));
        tick();
        chk("cap_user_input", user_input, pat);
        chk("cap_edit_game_state", 256'(game_state), 256'(0));
        chk("cap_edit_freeze", 256'(freeze), 256'(1));

        // reset while running discards the buffer and cursor
        run_sw = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("rrst_game_state", 256'(game_state), 256'(0));
        chk("rrst_freeze", 256'(freeze), 256'(1));
        chk("rrst_user_input", user_input, '0);
        chk("rrst_row", 256'(cursor_row), 256'(0));
        chk("rrst_col", 256'(cursor_col), 256'(0));
        reset = 1'b0;
        run_sw = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_keys({$urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
            if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
            for (int r = 0; r < G; r++) cell_status[r] = 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
